// File: rtl/fb_burst_arbiter.sv
// SDRAM frame-buffer burst arbiter between the camera write path and the LCD read path.
// Optional ping-pong frame banks are enabled by defining PINGPONG_EN.
module fb_burst_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int LVL_W       = 10,
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int RD_LOW      = 256,
    parameter int WR_HIGH     = 256,
    parameter int MAX_RD_RUN  = 4
`ifdef PINGPONG_EN
    ,
    parameter logic [ADDR_W-1:0] BANK_OFS = 24'h080000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic [LVL_W-1:0]  wr_fifo_lvl,
    input  logic [LVL_W-1:0]  rd_fifo_lvl,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_RD_RUN + 1);
    localparam logic [LVL_W-1:0]  RD_LOW_L  = LVL_W'(RD_LOW);
    localparam logic [LVL_W-1:0]  WR_HIGH_L = LVL_W'(WR_HIGH);
    localparam logic [CNT_W-1:0]  RUN_MAX   = CNT_W'(MAX_RD_RUN);
    localparam logic [ADDR_W-1:0] BL        = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(FRAME_WORDS - BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic               rd_active_q, rd_active_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic               wr_pend_q, wr_pend_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_need, wr_need, wr_busy, rd_busy;
    logic [ADDR_W-1:0]  wr_base, rd_base;
`ifdef PINGPONG_EN
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
`endif

    function automatic logic [ADDR_W-1:0] ptr_advance(input logic [ADDR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + BL;
    endfunction

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_active_d = rd_active_q;
        run_d       = run_q;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
`ifdef PINGPONG_EN
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
`endif
        rd_need = rd_active_q && (rd_fifo_lvl < RD_LOW_L);
        wr_need = wr_fifo_lvl >= WR_HIGH_L;
        wr_busy = (state_q != IDLE) && we_q;
        rd_busy = (state_q != IDLE) && !we_q;

        // A pointer in use by the current burst is rebased only when that burst finishes.
        if (wr_frame_start) begin
            if (wr_busy) wr_pend_d = 1'b1;
            else         wr_ptr_d  = '0;
`ifdef PINGPONG_EN
            wr_bank_d = ~wr_bank_q;
`endif
        end
        if (rd_frame_start) begin
            if (rd_busy)   rd_pend_d   = 1'b1;
            else           rd_ptr_d    = '0;
            if (init_done) rd_active_d = 1'b1;
`ifdef PINGPONG_EN
            rd_bank_d = ~wr_bank_q;
`endif
        end

`ifdef PINGPONG_EN
        wr_base = wr_bank_d ? BANK_OFS : '0;
        rd_base = rd_bank_d ? BANK_OFS : '0;
`else
        wr_base = '0;
        rd_base = '0;
`endif

        if (!wr_need) run_d = '0;

        case (state_q)
            IDLE: begin
                if (init_done) begin
                    if (rd_need && !(wr_need && run_q == RUN_MAX)) begin
                        state_d = REQ;
                        we_d    = 1'b0;
                        addr_d  = rd_base + rd_ptr_d;
                        if (wr_need && run_q != RUN_MAX) run_d = run_q + 1'b1;
                    end else if (wr_need) begin
                        state_d = REQ;
                        we_d    = 1'b1;
                        addr_d  = wr_base + wr_ptr_d;
                        run_d   = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (mem_done) begin
                    state_d = IDLE;
                    if (we_q) begin
                        wr_ptr_d  = (wr_pend_q || wr_frame_start) ? '0 : ptr_advance(wr_ptr_q);
                        wr_pend_d = 1'b0;
                    end else begin
                        rd_ptr_d  = (rd_pend_q || rd_frame_start) ? '0 : ptr_advance(rd_ptr_q);
                        rd_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_active_q <= 1'b0;
            run_q       <= '0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
`ifdef PINGPONG_EN
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_active_q <= rd_active_d;
            run_q       <= run_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
`ifdef PINGPONG_EN
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
`endif
        end
    end

    assign mem_req  = (state_q == REQ);
    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fb_burst_arbiter.sv
// Bench for fb_burst_arbiter: directed scenarios plus randomized bursts against a
// frame-pointer/bank reference model. Define PINGPONG_EN for both RTL and bench to cover banking.
module tb_fb_burst_arbiter;

    localparam int ADDR_W   = 24;
    localparam int LVL_W    = 10;
    localparam int BL       = 256;
    localparam int FW       = 307200;
    localparam int RD_LOW   = 256;
    localparam int WR_HIGH  = 256;
    localparam int MAXR     = 4;
    localparam int BANK_OFS = 'h080000;
`ifdef PINGPONG_EN
    localparam int WB1 = BANK_OFS;
`else
    localparam int WB1 = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done = 1'b0;
    logic [LVL_W-1:0]  wr_fifo_lvl = '0;
    logic [LVL_W-1:0]  rd_fifo_lvl = '0;
    logic              wr_frame_start = 1'b0;
    logic              rd_frame_start = 1'b0;
    logic              mem_ack = 1'b0;
    logic              mem_done = 1'b0;
    logic              mem_req, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    fb_burst_arbiter dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .wr_fifo_lvl(wr_fifo_lvl), .rd_fifo_lvl(rd_fifo_lvl),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_done(mem_done), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_wr_ptr, m_rd_ptr, m_run, cur_w, cur_r;
    bit m_rd_active, m_wr_pend, m_rd_pend, m_wr_bank, m_rd_bank;
    int last_addr;
    bit last_we;
    bit drop_init;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_addr(input bit we);
        int base;
        base = 0;
`ifdef PINGPONG_EN
        base = (we ? m_wr_bank : m_rd_bank) ? BANK_OFS : 0;
`endif
        return (base + (we ? m_wr_ptr : m_rd_ptr)) & ((1 << ADDR_W) - 1);
    endfunction

    function automatic int next_ptr(input int p);
        return (p + BL >= FW) ? 0 : p + BL;
    endfunction

    task automatic model_reset();
        m_wr_ptr = 0; m_rd_ptr = 0; m_run = 0;
        m_rd_active = 0; m_wr_pend = 0; m_rd_pend = 0;
        m_wr_bank = 0; m_rd_bank = 0;
    endtask

    task automatic set_levels(input int w, input int r);
        wr_fifo_lvl = LVL_W'(w);
        rd_fifo_lvl = LVL_W'(r);
        cur_w = w;
        cur_r = r;
        if (w < WR_HIGH) m_run = 0;
    endtask

    // Arbitration rule applied to the current levels and history.
    task automatic predict(output bit grant, output bit we);
        bit rdn, wrn;
        rdn = m_rd_active && (cur_r < RD_LOW);
        wrn = cur_w >= WR_HIGH;
        grant = 1'b1;
        we    = 1'b0;
        if (rdn && !(wrn && m_run == MAXR)) begin
            m_run = wrn ? ((m_run < MAXR) ? m_run + 1 : m_run) : 0;
        end else if (wrn) begin
            we = 1'b1;
            m_run = 0;
        end else begin
            grant = 1'b0;
            m_run = 0;
        end
    endtask

    task automatic model_pulse(input bit is_wr, input bit in_burst, input bit burst_we);
        if (is_wr) begin
            if (in_burst && burst_we) m_wr_pend = 1;
            else                      m_wr_ptr = 0;
            m_wr_bank = ~m_wr_bank;
        end else begin
            if (in_burst && !burst_we) m_rd_pend = 1;
            else                       m_rd_ptr = 0;
            m_rd_active = 1;
            m_rd_bank = ~m_wr_bank;
        end
    endtask

    task automatic pulse_idle(input bit is_wr);
        chk("pulse_idle_busy", busy, 0);
        if (is_wr) wr_frame_start = 1'b1;
        else       rd_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        model_pulse(is_wr, 0, 0);
    endtask

    // One arbitration round as seen by the SDRAM controller side.
    task automatic burst(input int ack_dly, input int done_dly_in, input int nw, input int nr, input int fs);
        bit g, we, found;
        int ea, done_dly;
        done_dly = (fs != 0 && done_dly_in == 0) ? 1 : done_dly_in;
        predict(g, we);
        if (!g) begin
            mem_ack = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                mem_ack = 1'b0;
                chk("idle_noreq", mem_req, 0);
            end
            set_levels(nw, nr);
            return;
        end
        ea = exp_addr(we);
        found = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (mem_req) begin
                found = 1;
                break;
            end
        end
        chk("req_seen", found, 1);
        if (!found) begin
            set_levels(nw, nr);
            return;
        end
        last_addr = mem_addr;
        last_we   = mem_we;
        chk("grant_we", mem_we, we);
        chk("grant_addr", mem_addr, ea);
        for (int i = 0; i < ack_dly; i++) begin
            mem_done = (i == 1);
            tick();
            mem_done = 1'b0;
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, ea);
            chk("we_hold", mem_we, we);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("req_drop", mem_req, 0);
        chk("busy_wait", busy, 1);
        for (int i = 0; i < done_dly; i++) begin
            if (i == 0 && fs == 1) wr_frame_start = 1'b1;
            if (i == 0 && fs == 2) rd_frame_start = 1'b1;
            if (i == 0 && drop_init) init_done = 1'b0;
            tick();
            if (wr_frame_start) model_pulse(1, 1, we);
            if (rd_frame_start) model_pulse(0, 1, we);
            wr_frame_start = 1'b0;
            rd_frame_start = 1'b0;
            chk("busy_hold", busy, 1);
        end
        mem_done = 1'b1;
        set_levels(nw, nr);
        tick();
        mem_done = 1'b0;
        if (we) begin
            m_wr_ptr = m_wr_pend ? 0 : next_ptr(m_wr_ptr);
            m_wr_pend = 0;
        end else begin
            m_rd_ptr = m_rd_pend ? 0 : next_ptr(m_rd_ptr);
            m_rd_pend = 0;
        end
        chk("idle_gap", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        model_reset();
        drop_init = 0;

        // Reset and init gating
        set_levels(300, 1000);
        tick(); tick();
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("init_gate", mem_req, 0);
        end
        init_done = 1'b1;

        // First write with slow ack, then the next write at 256
        burst(5, 2, 300, 1000, 0);
        chk("t1_addr", last_addr, 0);
        burst(1, 1, 0, 1000, 0);
        chk("t2_addr", last_addr, 256);

        // Read/write fairness under sustained demand
        burst(0, 0, 0, 1000, 0);
        pulse_idle(0);
        set_levels(300, 10);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            burst(0, 1, (i == 9) ? 0 : 300, (i == 9) ? 1000 : 10, 0);
            pat = {pat[8:0], last_we};
        end
        chk("t3_pattern", pat, 10'b0000100001);

        // Frame start during a write burst at ptr 1024
        set_levels(300, 1000);
        burst(0, 2, 300, 1000, 1);
        chk("t5_at1024", last_addr, 1024);
        burst(0, 0, 0, 1000, 0);
        chk("t5_rebase", last_addr, WB1);

        // Frame wrap
        burst(0, 0, 0, 1000, 0);
        pulse_idle(1);
        set_levels(300, 1000);
        for (int i = 1; i <= 1201; i++) begin
            burst(0, 0, (i == 1201) ? 0 : 300, 1000, 0);
            if (i == 1200) chk("t4_last", last_addr, FW - BL);
            if (i == 1201) chk("t4_wrap", last_addr, 0);
        end
        burst(0, 0, 0, 1000, 0);

        // Randomized traffic
        set_levels(300, 10);
        for (int i = 0; i < 80; i++) begin
            int nw, nr, fs;
            nw = (i == 79) ? 0 : int'($urandom_range(0, 1023));
            nr = (i == 79) ? 1000 : int'($urandom_range(0, 1023));
            fs = int'($urandom_range(0, 5));
            if (fs > 2) fs = 0;
            burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), nw, nr, fs);
        end
        burst(0, 0, 0, 1000, 0);

        // init_done dropped mid-burst: burst finishes, no new grants
        set_levels(300, 1000);
        drop_init = 1;
        burst(2, 2, 300, 1000, 0);
        drop_init = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("init_drop_noreq", mem_req, 0);
        end
        init_done = 1'b1;
        burst(0, 1, 300, 1000, 0);
        chk("init_resume_nz", (last_addr != 0), 1);

        // Asynchronous reset in the middle of a burst
        tick();
        chk("rst_mid_req", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req0", mem_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_we", mem_we, 0);
        model_reset();
        set_levels(0, 1000);
        tick();
        rst_n = 1'b1;
        tick();

        // Bank selection
        pulse_idle(1);
        pulse_idle(0);
        set_levels(300, 1000);
        burst(0, 1, 0, 10, 0);
        chk("t6_wr_bank", last_addr, WB1);
        burst(0, 1, 0, 1000, 0);
        chk("t6_rd_bank", last_addr, 0);
        chk("t6_rd_we", last_we, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
